mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 493 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Two-way round-robin arbiter that shares one fixed-latency
//             memory port between an instruction cache (read-only fills) and
//             a data cache (fills and write-backs). One transaction is in
//             flight at a time: IDLE -> STROBE -> WAIT -> DONE -> IDLE.
//
//  Parameters
//    MEM_LATENCY  : cycles from the mem_en cycle to the cycle in which
//                   mem_rdata is valid (1..15).
//    RESET_PRIO_D : 1 = the data cache wins the first tie after reset,
//                   0 = the instruction cache wins it.
//
//  Ports
//    clk        in   1   sole clock, rising edge
//    reset      in   1   asynchronous, active-low reset
//    i_req      in   1   instruction fill request, held until i_done
//    i_addr     in  32   instruction fetch address
//    i_done     out  1   one-cycle instruction completion pulse
//    i_rdata    out 32   instruction read word (holds until next I fill)
//    d_req      in   1   data request, held until d_done
//    d_we       in   1   1 = write-back, 0 = fill
//    d_addr     in  32   data address
//    d_wdata    in  32   write word, byte 0 in [31:24]
//    d_done     out  1   one-cycle data completion pulse
//    d_rdata    out 32   data read word (holds until next D transaction)
//    mem_en     out  1   one-cycle memory access strobe
//    mem_we     out  1   write qualifier, valid with mem_en
//    mem_addr   out 32   access address, held from strobe until done
//    mem_wdata  out 32   write word, valid with mem_en
//    mem_rdata  in  32   read word, valid MEM_LATENCY cycles after mem_en
//    busy       out  1   high whenever the FSM is not in IDLE
//
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
  parameter int unsigned MEM_LATENCY  = 4,
  parameter int unsigned RESET_PRIO_D = 1
) (
  input  logic        clk,
  input  logic        reset,
  // instruction side
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_done,
  output logic [31:0] i_rdata,
  // data side
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  // memory side
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  // status
  output logic        busy
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  // Four bits cover the full latency range: the counter is loaded with
  // MEM_LATENCY-1, at most 14.
  localparam int unsigned      CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t           state_q,         state_d;
  logic             sel_dc_q,        sel_dc_d;        // 1 = data cache owns the transaction
  logic             rr_prefer_dc_q,  rr_prefer_dc_d;  // winner of the next tie
  logic             we_q,            we_d;
  logic [31:0]      addr_q,          addr_d;
  logic [31:0]      wdata_q,         wdata_d;
  logic [CNT_W-1:0] cnt_q,           cnt_d;
  logic [31:0]      i_rdata_q,       i_rdata_d;
  logic [31:0]      d_rdata_q,       d_rdata_d;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic w_any_req;
  logic w_grant_dc;

  assign w_any_req = i_req | d_req;

  // A lone requester always wins; on a tie the round-robin pointer decides.
  assign w_grant_dc = d_req & (~i_req | rr_prefer_dc_q);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      sel_dc_q       <= 1'b0;
      rr_prefer_dc_q <= (RESET_PRIO_D != 0);
      we_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      cnt_q          <= '0;
      i_rdata_q      <= '0;
      d_rdata_q      <= '0;
    end else begin
      state_q        <= state_d;
      sel_dc_q       <= sel_dc_d;
      rr_prefer_dc_q <= rr_prefer_dc_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      cnt_q          <= cnt_d;
      i_rdata_q      <= i_rdata_d;
      d_rdata_q      <= d_rdata_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    sel_dc_d       = sel_dc_q;
    rr_prefer_dc_d = rr_prefer_dc_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    cnt_d          = cnt_q;
    i_rdata_d      = i_rdata_q;
    d_rdata_d      = d_rdata_q;

    case (state_q)
      IDLE: begin
        // Requests are only looked at here, so anything raised or dropped
        // while a transaction runs has no effect until the FSM is back.
        if (w_any_req) begin
          sel_dc_d       = w_grant_dc;
          rr_prefer_dc_d = ~w_grant_dc;
          addr_d         = w_grant_dc ? d_addr : i_addr;
          // Instruction fills never write; clear the write path for them.
          we_d           = w_grant_dc & d_we;
          wdata_d        = w_grant_dc ? d_wdata : '0;
          state_d        = STROBE;
        end
      end

      STROBE: begin
        cnt_d   = CNT_LOAD;
        state_d = WAIT;
      end

      WAIT: begin
        // Counter reaches zero in the cycle mem_rdata is valid; capture it
        // into the owner's read register on the way out (writes included).
        if (cnt_q == '0) begin
          state_d = DONE;
          if (sel_dc_q) begin
            d_rdata_d = mem_rdata;
          end else begin
            i_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // All outputs decode registered state, so they drop to zero the moment the
  // asynchronous reset clears the registers.
  assign mem_en    = (state_q == STROBE);
  assign mem_we    = (state_q == STROBE) & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign i_done    = (state_q == DONE) & ~sel_dc_q;
  assign d_done    = (state_q == DONE) &  sel_dc_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

  assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Self-checking bench for mem_arbiter. Two instances are built:
//             u_dut with the default latency of 4 and u_dut1 with latency 1.
//             A memory responder per instance returns a fresh random word
//             exactly MEM_LATENCY cycles after each strobe and random junk at
//             every other time. Directed scenarios use cycle numbers relative
//             to the request cycle (cycle 0); the randomized scenario checks
//             against a cycle-arithmetic model of the arbitration rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int L0 = 4;
  localparam int L1 = 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  // instance 0 (latency 4)
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic        i_done, d_done, mem_en, mem_we, busy;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;

  // instance 1 (latency 1)
  logic        i_req1 = 1'b0, d_req1 = 1'b0, d_we1 = 1'b0;
  logic [31:0] i_addr1 = '0, d_addr1 = '0, d_wdata1 = '0, mem_rdata1 = '0;
  logic        i_done1, d_done1, mem_en1, mem_we1, busy1;
  logic [31:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  mem_arbiter #(.MEM_LATENCY(L0), .RESET_PRIO_D(1)) u_dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.MEM_LATENCY(L1), .RESET_PRIO_D(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .i_req(i_req1), .i_addr(i_addr1), .i_done(i_done1), .i_rdata(i_rdata1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_done(d_done1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .busy(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // --------------------------------------------------------------------------
  // Memory responders: one outstanding access at most per instance.
  // --------------------------------------------------------------------------
  int          due0 = -100, due1 = -100;
  logic [31:0] due_data0 = '0, due_data1 = '0;
  logic [31:0] last0 = '0, last1 = '0;     // word returned for latest strobe
  bit          fix0 = 1'b0;
  logic [31:0] fix_data0 = '0;

  always @(negedge clk) begin
    if (!reset) begin
      due0 = -100;
    end else if (mem_en) begin
      due_data0 = fix0 ? fix_data0 : $urandom;
      last0     = due_data0;
      due0      = cyc + L0;
    end
    mem_rdata = (cyc == due0) ? due_data0 : $urandom;
  end

  always @(negedge clk) begin
    if (!reset) begin
      due1 = -100;
    end else if (mem_en1) begin
      due_data1 = $urandom;
      last1     = due_data1;
      due1      = cyc + L1;
    end
    mem_rdata1 = (cyc == due1) ? due_data1 : $urandom;
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (no checking)
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    i_req1 = 0; i_addr1 = '0; d_req1 = 0; d_we1 = 0; d_addr1 = '0; d_wdata1 = '0;
  endtask

  // Returns #1 after the first edge following release; that cycle is idle.
  task automatic do_reset();
    clear_inputs();
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    tick();
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    clear_inputs();
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({mem_en, mem_we, i_done, d_done, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 00000", {mem_en, mem_we, i_done, d_done, busy});
    end
    n_checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mem_bus: got addr %h wdata %h expected 0", mem_addr, mem_wdata);
    end
    n_checks++;
    if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rdata: got i %h d %h expected 0", i_rdata, d_rdata);
    end
    n_checks++;
    if ({mem_en1, busy1, i_done1, d_done1} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_dut1: got %b expected 0000", {mem_en1, busy1, i_done1, d_done1});
    end
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if (busy !== 1'b0 || mem_en !== 1'b0 || i_done !== 1'b0 || d_done !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_quiet c=%0d: got busy %b en %b id %b dd %b expected 0",
                 c, busy, mem_en, i_done, d_done);
      end
    end
  endtask

  task automatic test_tie_after_reset();
    i_req = 1; i_addr = 32'h300; d_req = 1; d_we = 0; d_addr = 32'h400;
    for (int c = 1; c <= 14; c++) begin
      tick();
      n_checks++;
      if (mem_en !== (c == 1 || c == 8)) begin
        n_fail++;
        $display("FAIL tie_mem_en c=%0d: got %b expected %b", c, mem_en, (c == 1 || c == 8));
      end
      if (c == 1) begin
        n_checks++;
        if (mem_addr !== 32'h400) begin
          n_fail++;
          $display("FAIL tie_first_addr: got %h expected 00000400", mem_addr);
        end
      end
      if (c == 8) begin
        n_checks++;
        if (mem_addr !== 32'h300) begin
          n_fail++;
          $display("FAIL tie_second_addr: got %h expected 00000300", mem_addr);
        end
      end
      n_checks++;
      if (d_done !== (c == 6)) begin
        n_fail++;
        $display("FAIL tie_d_done c=%0d: got %b expected %b", c, d_done, (c == 6));
      end
      n_checks++;
      if (i_done !== (c == 13)) begin
        n_fail++;
        $display("FAIL tie_i_done c=%0d: got %b expected %b", c, i_done, (c == 13));
      end
      if (c == 6) begin
        n_checks++;
        if (d_rdata !== last0) begin
          n_fail++;
          $display("FAIL tie_d_rdata: got %h expected %h", d_rdata, last0);
        end
        d_req = 0;
      end
      if (c == 13) begin
        n_checks++;
        if (i_rdata !== last0) begin
          n_fail++;
          $display("FAIL tie_i_rdata: got %h expected %h", i_rdata, last0);
        end
        i_req = 0;
      end
    end
  endtask

  task automatic test_single_ifill();
    fix0 = 1; fix_data0 = 32'hDEADBEEF;
    i_req = 1; i_addr = 32'h100;
    for (int c = 1; c <= 8; c++) begin
      tick();
      n_checks++;
      if (mem_en !== (c == 1)) begin
        n_fail++;
        $display("FAIL ifill_mem_en c=%0d: got %b expected %b", c, mem_en, (c == 1));
      end
      if (c == 1) begin
        n_checks++;
        if (mem_addr !== 32'h100 || mem_we !== 1'b0) begin
          n_fail++;
          $display("FAIL ifill_strobe: got addr %h we %b expected 00000100 0", mem_addr, mem_we);
        end
      end
      n_checks++;
      if (i_done !== (c == 6) || d_done !== 1'b0) begin
        n_fail++;
        $display("FAIL ifill_done c=%0d: got i %b d %b expected %b 0", c, i_done, d_done, (c == 6));
      end
      n_checks++;
      if (busy !== (c <= 6)) begin
        n_fail++;
        $display("FAIL ifill_busy c=%0d: got %b expected %b", c, busy, (c <= 6));
      end
      if (c >= 6) begin
        n_checks++;
        if (i_rdata !== 32'hDEADBEEF) begin
          n_fail++;
          $display("FAIL ifill_rdata c=%0d: got %h expected deadbeef", c, i_rdata);
        end
      end
      if (c == 6) i_req = 0;
    end
    fix0 = 0;
  endtask

  task automatic test_fairness();
    i_req = 1; i_addr = 32'h500; d_req = 1; d_we = 0; d_addr = 32'h600;
    for (int c = 1; c <= 28; c++) begin
      bit exp_strobe, exp_id, exp_dd;
      tick();
      exp_strobe = ((c - 1) % 7 == 0) && ((c - 1) / 7 < 4);
      exp_dd     = (c >= 6) && ((c - 6) % 7 == 0) && ((c - 6) / 7 < 4) && ((c - 6) / 7 % 2 == 0);
      exp_id     = (c >= 6) && ((c - 6) % 7 == 0) && ((c - 6) / 7 < 4) && ((c - 6) / 7 % 2 == 1);
      n_checks++;
      if (mem_en !== exp_strobe) begin
        n_fail++;
        $display("FAIL fair_mem_en c=%0d: got %b expected %b", c, mem_en, exp_strobe);
      end
      if (exp_strobe) begin
        n_checks++;
        if (mem_addr !== ((((c - 1) / 7) % 2 == 0) ? 32'h600 : 32'h500)) begin
          n_fail++;
          $display("FAIL fair_grant c=%0d: got addr %h expected %h", c, mem_addr,
                   ((((c - 1) / 7) % 2 == 0) ? 32'h600 : 32'h500));
        end
      end
      n_checks++;
      if (d_done !== exp_dd || i_done !== exp_id) begin
        n_fail++;
        $display("FAIL fair_done c=%0d: got d %b i %b expected d %b i %b", c, d_done, i_done, exp_dd, exp_id);
      end
      if (exp_dd || exp_id) begin
        n_checks++;
        if ((exp_dd ? d_rdata : i_rdata) !== last0) begin
          n_fail++;
          $display("FAIL fair_rdata c=%0d: got %h expected %h", c, (exp_dd ? d_rdata : i_rdata), last0);
        end
      end
      if (c == 27) begin i_req = 0; d_req = 0; end
    end
  endtask

  task automatic test_writeback();
    d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'h11223344;
    for (int c = 1; c <= 7; c++) begin
      tick();
      n_checks++;
      if (mem_en !== (c == 1)) begin
        n_fail++;
        $display("FAIL wb_mem_en c=%0d: got %b expected %b", c, mem_en, (c == 1));
      end
      if (c == 1) begin
        n_checks++;
        if (mem_we !== 1'b1 || mem_wdata !== 32'h11223344 || mem_addr !== 32'h2000) begin
          n_fail++;
          $display("FAIL wb_strobe: got we %b wdata %h addr %h expected 1 11223344 00002000",
                   mem_we, mem_wdata, mem_addr);
        end
      end
      n_checks++;
      if (d_done !== (c == 6) || i_done !== 1'b0) begin
        n_fail++;
        $display("FAIL wb_done c=%0d: got d %b i %b expected %b 0", c, d_done, i_done, (c == 6));
      end
      if (c == 6) begin
        n_checks++;
        if (d_rdata !== last0) begin
          n_fail++;
          $display("FAIL wb_rdata: got %h expected %h", d_rdata, last0);
        end
        d_req = 0; d_we = 0;
      end
    end
  endtask

  task automatic test_reset_mid_op();
    d_req = 1; d_we = 0; d_addr = 32'h700;
    for (int c = 1; c <= 3; c++) tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre_busy: got %b expected 1", busy);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({mem_en, mem_we, i_done, d_done, busy} !== 5'b0 || mem_addr !== 32'h0 ||
        mem_wdata !== 32'h0 || i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got ctl %b addr %h wdata %h ir %h dr %h expected all 0",
               {mem_en, mem_we, i_done, d_done, busy}, mem_addr, mem_wdata, i_rdata, d_rdata);
    end
    d_req = 0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if (i_done !== 1'b0 || d_done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_after c=%0d: got id %b dd %b busy %b expected 0", c, i_done, d_done, busy);
      end
    end
    test_tie_after_reset();
  endtask

  task automatic test_min_latency();
    d_req1 = 1; d_we1 = 0; d_addr1 = 32'h800;
    for (int c = 1; c <= 5; c++) begin
      tick();
      n_checks++;
      if (mem_en1 !== (c == 1)) begin
        n_fail++;
        $display("FAIL minlat_mem_en c=%0d: got %b expected %b", c, mem_en1, (c == 1));
      end
      if (c == 1) begin
        n_checks++;
        if (mem_addr1 !== 32'h800) begin
          n_fail++;
          $display("FAIL minlat_addr: got %h expected 00000800", mem_addr1);
        end
      end
      n_checks++;
      if (busy1 !== (c <= 3)) begin
        n_fail++;
        $display("FAIL minlat_busy c=%0d: got %b expected %b", c, busy1, (c <= 3));
      end
      n_checks++;
      if (d_done1 !== (c == 3) || i_done1 !== 1'b0) begin
        n_fail++;
        $display("FAIL minlat_done c=%0d: got d %b i %b expected %b 0", c, d_done1, i_done1, (c == 3));
      end
      if (c == 3) begin
        n_checks++;
        if (d_rdata1 !== last1) begin
          n_fail++;
          $display("FAIL minlat_rdata: got %h expected %h", d_rdata1, last1);
        end
        d_req1 = 0;
      end
    end
  endtask

  // Randomized traffic against a model that only knows the rules: a grant
  // happens in an idle cycle with a request present, the strobe follows one
  // cycle later, done comes MEM_LATENCY+2 cycles after the grant cycle, and
  // the arbiter samples again MEM_LATENCY+3 cycles after the grant cycle.
  task automatic test_random();
    int          free_at, strobe_t, done_t;
    bit          prio_d, g_isd, have, i_fly, d_fly;
    logic        g_we;
    logic [31:0] g_addr, g_wdata, exp_ir, exp_dr;
    do_reset();
    prio_d = 1; have = 0; free_at = 0; strobe_t = -10; done_t = -10;
    g_isd = 0; g_we = 0; g_addr = '0; g_wdata = '0; exp_ir = '0; exp_dr = '0;
    for (int t = 0; t < 600; t++) begin
      if (have && t == done_t) begin
        if (g_isd) exp_dr = last0; else exp_ir = last0;
      end
      n_checks++;
      if (mem_en !== (have && t == strobe_t)) begin
        n_fail++;
        $display("FAIL rnd_mem_en t=%0d: got %b expected %b", t, mem_en, (have && t == strobe_t));
      end
      if (have && t == strobe_t) begin
        n_checks++;
        if (mem_we !== g_we || (g_we && mem_wdata !== g_wdata)) begin
          n_fail++;
          $display("FAIL rnd_strobe t=%0d: got we %b wdata %h expected %b %h", t, mem_we, mem_wdata, g_we, g_wdata);
        end
      end
      if (have && t >= strobe_t && t <= done_t) begin
        n_checks++;
        if (mem_addr !== g_addr) begin
          n_fail++;
          $display("FAIL rnd_addr t=%0d: got %h expected %h", t, mem_addr, g_addr);
        end
      end
      n_checks++;
      if (i_done !== (have && t == done_t && !g_isd) || d_done !== (have && t == done_t && g_isd)) begin
        n_fail++;
        $display("FAIL rnd_done t=%0d: got i %b d %b expected i %b d %b", t, i_done, d_done,
                 (have && t == done_t && !g_isd), (have && t == done_t && g_isd));
      end
      n_checks++;
      if (busy !== (have && t >= strobe_t && t <= done_t)) begin
        n_fail++;
        $display("FAIL rnd_busy t=%0d: got %b expected %b", t, busy, (have && t >= strobe_t && t <= done_t));
      end
      n_checks++;
      if (i_rdata !== exp_ir || d_rdata !== exp_dr) begin
        n_fail++;
        $display("FAIL rnd_rdata t=%0d: got i %h d %h expected i %h d %h", t, i_rdata, d_rdata, exp_ir, exp_dr);
      end

      // requester behaviour
      if (have && t == done_t) begin
        if (g_isd) d_req = 0; else i_req = 0;
      end
      i_fly = have && !g_isd && t < done_t;
      d_fly = have &&  g_isd && t < done_t;
      if (i_fly) begin
        i_addr = $urandom;                      // changes after grant are ignored
      end else if (i_req) begin
        if ($urandom_range(0, 7) == 0) i_req = 0;  // withdraw before grant
      end else if ($urandom_range(0, 2) == 0) begin
        i_req = 1; i_addr = $urandom;
      end
      if (d_fly) begin
        d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom_range(0, 1));
      end else if (d_req) begin
        if ($urandom_range(0, 7) == 0) d_req = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        d_req = 1; d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom_range(0, 1));
      end

      // grant decision at the end of this cycle
      if (t >= free_at && (i_req || d_req)) begin
        g_isd    = d_req && (!i_req || prio_d);
        prio_d   = !g_isd;
        g_addr   = g_isd ? d_addr : i_addr;
        g_we     = g_isd && d_we;
        g_wdata  = d_wdata;
        strobe_t = t + 1;
        done_t   = t + L0 + 2;
        free_at  = t + L0 + 3;
        have     = 1;
      end
      tick();
    end
    clear_inputs();
    repeat (10) tick();
  endtask

  initial begin
    test_reset();
    test_tie_after_reset();
    test_single_ifill();
    test_fairness();
    test_writeback();
    test_reset_mid_op();
    test_min_latency();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule
`default_nettype wire
